vga_fb_arbiter: RTL

- Shares one single-port synchronous framebuffer RAM (12-bit RGB words) between two requesters: VGA scanout (reads) and game logic (writes).
- Prefetches scanout pixels into a small FIFO ahead of the pixel consumer and grants idle memory cycles to the writer.
- Sits between the game-state logic, the framebuffer RAM and the vga pixel/sync generator, all in the single system clock domain.

---
 rtl/vga_fb_pkg.sv | 8 +
 rtl/vga_fb_fifo.sv | 35 +++
 rtl/vga_fb_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared RGB width, arbiter state type and frame-size helper
package vga_fb_pkg;
  localparam int RGB_W = 12;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  function automatic int fb_size(input int w, input int h);
    return w * h;
  endfunction
endpackage

// File: rtl/vga_fb_fifo.sv
// vga_fb_fifo: synchronous prefetch FIFO with flush, occupancy count and zero data when empty
module vga_fb_fifo
  import vga_fb_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [RGB_W-1:0] din,
  output logic [RGB_W-1:0] dout,
  output logic [CW-1:0]    count
);
  logic [RGB_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  // storage needs no reset; the pointers alone define which entries are live
  always_ff @(posedge clock) if (push) mem[wp] <= din;
  // pointers and count; a flush empties the queue without touching storage
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout = (count == '0) ? '0 : mem[rp];
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one framebuffer RAM between scanout prefetch and game writes (optional VGA_FB_UNDERFLOW_CNT_EN adds io_underflow_count)
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int ADDR_W = 15,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_frame_start,
  input  logic              io_pix_ready,
  output logic              io_pix_valid,
  output logic [RGB_W-1:0]  io_pix_data,
  output logic              io_underflow,
`ifdef VGA_FB_UNDERFLOW_CNT_EN
  output logic [15:0]       io_underflow_count,
`endif
  input  logic              io_wr_valid,
  output logic              io_wr_ready,
  input  logic [ADDR_W-1:0] io_wr_addr,
  input  logic [RGB_W-1:0]  io_wr_data,
  output logic              io_mem_en,
  output logic              io_mem_we,
  output logic [ADDR_W-1:0] io_mem_addr,
  output logic [RGB_W-1:0]  io_mem_wdata,
  input  logic [RGB_W-1:0]  io_mem_rdata
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(fb_size(FB_W, FB_H) - 1);
  localparam logic [CW:0] LW = (CW+1)'(LOW_WATER);
  localparam logic [CW:0] FD = (CW+1)'(FIFO_DEPTH);
  state_t state, state_nx;
  logic [ADDR_W-1:0] scan_addr;
  logic rd_inflight, read_urgent, read_possible, wr_go, wr_hit, rd_go, push, pop, uf_evt;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  // arbitration: the writer wins unless scanout is starving; a frame_start cycle never reads
  always_comb begin
    occ = {1'b0, count} + (CW+1)'(rd_inflight);
    read_urgent = (state == SCAN) && (occ < LW);
    read_possible = (state == SCAN) && (occ < FD) && !io_frame_start;
    io_wr_ready = io_frame_start || !read_urgent;
    wr_go = io_wr_valid && io_wr_ready && !reset;
    wr_hit = wr_go && (io_wr_addr <= LAST);
    rd_go = !wr_go && read_possible && !reset;
    io_mem_en = wr_hit || rd_go;
    io_mem_we = wr_hit;
    io_mem_addr = wr_hit ? io_wr_addr : (rd_go ? scan_addr : '0);
    io_mem_wdata = wr_hit ? io_wr_data : '0;
    io_pix_valid = count != '0;
    push = rd_inflight && !io_frame_start;
    pop = io_pix_ready && io_pix_valid && !io_frame_start;
    uf_evt = io_pix_ready && !io_pix_valid && (state == SCAN) && !io_frame_start;
    state_nx = io_frame_start ? SCAN : (rd_go && scan_addr == LAST) ? DONE : state;
  end
  // state register
  always_ff @(posedge clock) state <= reset ? IDLE : state_nx;
  // scan pointer, read-in-flight flag and sticky underflow
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_addr <= '0;
      rd_inflight <= 1'b0;
      io_underflow <= 1'b0;
    end else begin
      scan_addr <= io_frame_start ? '0 : rd_go ? scan_addr + 1'b1 : scan_addr;
      rd_inflight <= rd_go;
      io_underflow <= io_underflow || uf_evt;
    end
  end
`ifdef VGA_FB_UNDERFLOW_CNT_EN
  // saturating underflow event counter, restarted with every frame
  always_ff @(posedge clock) begin
    if (reset || io_frame_start) io_underflow_count <= '0;
    else if (uf_evt && io_underflow_count != 16'hFFFF) io_underflow_count <= io_underflow_count + 1'b1;
  end
`endif
  vga_fb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(io_frame_start),
    .push(push),
    .pop(pop),
    .din(io_mem_rdata),
    .dout(io_pix_data),
    .count(count)
  );
endmodule
